// File: rtl/dbgmem_arb_pkg.sv
// dbgmem_arb_pkg: shared types and default widths for the debug memory arbiter
package dbgmem_arb_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {GNT_JTAG, GNT_AVS} gnt_t;
endpackage

// File: rtl/dbgmem_rr_arb2.sv
// dbgmem_rr_arb2: two-way round robin arbiter with a JTAG priority override
module dbgmem_rr_arb2
  import dbgmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic prio_jtag,
  input  logic req_jtag,
  input  logic req_avs,
  output logic gnt_valid,
  output gnt_t gnt
);
  gnt_t last_grant;
  assign gnt_valid = en & (req_jtag | req_avs);
  assign gnt = (req_jtag & (prio_jtag | ~req_avs | last_grant == GNT_AVS)) ? GNT_JTAG : GNT_AVS;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_grant <= GNT_AVS;
    else if (gnt_valid) last_grant <= gnt;
endmodule

// File: rtl/testcore_nios2_gen2_f_dbgmem_arbiter.sv
// testcore_nios2_gen2_f_dbgmem_arbiter: shares the debug RAM between JTAG strobes and the Avalon debug slave.
// DBGMEM_AVS_WPROT_EN: when defined, Avalon writes outside debug mode are acknowledged but never reach the RAM.
module testcore_nios2_gen2_f_dbgmem_arbiter
  import dbgmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              debugack,
  input  logic              jtag_set_addr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_rd,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] mon_dreg,
  output logic              mon_ready,
  output logic              mon_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_t state;
  gnt_t gnt, gnt_w;
  logic gnt_v, op_wr, jpend, jop, jkill, j_acc, j_err, j_fly, j_done, a_done, a_we, fin;
  logic [ADDR_W-1:0] jaddr;
  logic [DATA_W-1:0] jwdata;
  dbgmem_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (state == IDLE),
    .prio_jtag (debugack),
    .req_jtag  (jpend),
    .req_avs   (avs_read | avs_write),
    .gnt_valid (gnt_v),
    .gnt       (gnt_w)
  );
`ifdef DBGMEM_AVS_WPROT_EN
  assign a_we = avs_write & debugack;
`else
  assign a_we = avs_write;
`endif
  assign fin = state == RESP || (state == ACCESS && op_wr);
  assign j_done = gnt == GNT_JTAG && fin;
  assign a_done = gnt == GNT_AVS && fin;
  assign j_fly = gnt == GNT_JTAG && state != IDLE;
  // jpend stays set until completion, so it also covers the in-flight window
  assign j_acc = (jtag_rd | jtag_wr) & ~jpend;
  assign j_err = ((jtag_rd | jtag_wr) & jpend) | (jtag_rd & jtag_wr);
  assign mon_ready = ~jpend;
  assign avs_waitrequest = (avs_read | avs_write) & ~a_done;
  assign avs_readdata = (state == RESP && gnt == GNT_AVS) ? ram_rdata : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= GNT_AVS;
      op_wr     <= 1'b0;
      jpend     <= 1'b0;
      jop       <= 1'b0;
      jkill     <= 1'b0;
      jaddr     <= '0;
      jwdata    <= '0;
      mon_dreg  <= '0;
      mon_error <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      mon_error <= j_err | (mon_error & ~jtag_set_addr);
      if (j_acc) begin
        jpend <= 1'b1;
        jop   <= jtag_wr;
        if (jtag_wr) jwdata <= jtag_wdata;
      end else if (j_done) jpend <= 1'b0;
      // an address load during an in-flight access cancels that access's increment
      jkill <= ~j_done & (jkill | (j_fly & jtag_set_addr));
      if (jtag_set_addr) jaddr <= jtag_addr;
      else if (j_done & ~jkill) jaddr <= jaddr + ADDR_W'(1);
      if (j_done & ~op_wr) mon_dreg <= ram_rdata;
      ram_we <= 1'b0;
      case (state)
        IDLE: if (gnt_v) begin
          state     <= ACCESS;
          gnt       <= gnt_w;
          op_wr     <= (gnt_w == GNT_JTAG) ? jop : avs_write;
          ram_we    <= (gnt_w == GNT_JTAG) ? jop : a_we;
          ram_addr  <= (gnt_w == GNT_JTAG) ? jaddr : avs_address;
          ram_wdata <= (gnt_w == GNT_JTAG) ? jwdata : avs_writedata;
        end
        ACCESS: state <= op_wr ? IDLE : RESP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_testcore_nios2_gen2_f_dbgmem_arbiter.sv
// tb_testcore_nios2_gen2_f_dbgmem_arbiter: directed plus randomized checks against a transaction-level memory model
module tb_testcore_nios2_gen2_f_dbgmem_arbiter;
`ifdef DBGMEM_AVS_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic debugack, jtag_set_addr, jtag_rd, jtag_wr, avs_read, avs_write, ram_we, mon_ready, mon_error, avs_waitrequest;
  logic [7:0] jtag_addr, avs_address, ram_addr, exp_jaddr;
  logic [31:0] jtag_wdata, avs_writedata, mon_dreg, avs_readdata, ram_wdata, ram_rdata;
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  testcore_nios2_gen2_f_dbgmem_arbiter dut (
    .clk(clk), .reset(reset), .debugack(debugack),
    .jtag_set_addr(jtag_set_addr), .jtag_addr(jtag_addr), .jtag_rd(jtag_rd), .jtag_wr(jtag_wr),
    .jtag_wdata(jtag_wdata), .mon_dreg(mon_dreg), .mon_ready(mon_ready), .mon_error(mon_error),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] seed(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 256; i++) ram[i] <= seed(i);
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!mon_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(tag, mon_ready, 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dreg"}, mon_dreg, 0);
    chk({tag, "_ready"}, mon_ready, 1);
    chk({tag, "_error"}, mon_error, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
    chk({tag, "_rdata"}, avs_readdata, 0);
    chk({tag, "_wait"}, avs_waitrequest, 0);
  endtask

  task automatic jtag_xfer(input bit sa, input logic [7:0] a, input bit wr, input logic [31:0] d);
    logic [7:0] ea;
    ea = sa ? a : exp_jaddr;
    jtag_set_addr = sa; jtag_addr = a; jtag_wr = wr; jtag_rd = !wr; jtag_wdata = d;
    @(negedge clk);
    jtag_set_addr = 0; jtag_rd = 0; jtag_wr = 0;
    chk("jtag_busy", mon_ready, 0);
    @(negedge clk);
    chk("jtag_addr", ram_addr, ea);
    chk("jtag_we", ram_we, wr);
    if (wr) begin
      chk("jtag_wdata", ram_wdata, d);
      ref_mem[ea] = d;
    end
    @(negedge clk);
    chk("jtag_we_pulse", ram_we, 0);
    if (!wr) begin
      chk("jtag_rd_busy", mon_ready, 0);
      @(negedge clk);
      chk("jtag_dreg", mon_dreg, ref_mem[ea]);
    end
    chk("jtag_ready", mon_ready, 1);
    exp_jaddr = 8'(ea + 1);
  endtask

  task automatic avs_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d);
    bit we_exp;
    we_exp = wr && (debugack || !WPROT);
    avs_address = a; avs_write = wr; avs_read = !wr; avs_writedata = d;
    #1 chk("avs_wait0", avs_waitrequest, 1);
    @(negedge clk);
    chk("avs_addr", ram_addr, a);
    chk("avs_we", ram_we, we_exp);
    if (wr) begin
      chk("avs_wait_w", avs_waitrequest, 0);
      if (we_exp) begin
        chk("avs_wdata", ram_wdata, d);
        ref_mem[a] = d;
      end
    end else begin
      chk("avs_wait_r1", avs_waitrequest, 1);
      @(negedge clk);
      chk("avs_wait_r", avs_waitrequest, 0);
      chk("avs_rdata", avs_readdata, ref_mem[a]);
    end
    avs_read = 0; avs_write = 0;
    @(negedge clk);
    chk("avs_idle_we", ram_we, 0);
    chk("avs_idle_rdata", avs_readdata, 0);
  endtask

  task automatic contest(input bit dbg, input bit exp_jtag);
    logic [7:0] aa, ja;
    bit a_ok, j_ok;
    ja = 8'($urandom);
    aa = ja ^ 8'h80;
    debugack = dbg;
    jtag_set_addr = 1; jtag_addr = ja; jtag_rd = 1;
    @(negedge clk);
    jtag_set_addr = 0; jtag_rd = 0;
    avs_address = aa; avs_read = 1;
    @(negedge clk);
    chk("arb_first", ram_addr, exp_jtag ? ja : aa);
    a_ok = 0; j_ok = 0;
    for (int i = 0; i < 12 && !(a_ok && j_ok); i++) begin
      if (!a_ok && !avs_waitrequest) begin
        chk("arb_avs_rdata", avs_readdata, ref_mem[aa]);
        avs_read = 0;
        a_ok = 1;
      end
      if (!j_ok && mon_ready) begin
        chk("arb_jtag_dreg", mon_dreg, ref_mem[ja]);
        j_ok = 1;
      end
      @(negedge clk);
    end
    chk("arb_both_done", {30'd0, a_ok, j_ok}, 3);
    exp_jaddr = 8'(ja + 1);
    debugack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] ea;
    logic [31:0] d;
    debugack = 0; jtag_set_addr = 0; jtag_addr = 0; jtag_rd = 0; jtag_wr = 0; jtag_wdata = 0;
    avs_address = 0; avs_read = 0; avs_write = 0; avs_writedata = 0;
    exp_jaddr = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    repeat (2) @(negedge clk);
    reset = 0;
    check_reset("rst1");
    jtag_xfer(1, 8'h10, 1, 32'hDEADBEEF);
    jtag_xfer(0, 8'h00, 0, 0);
    jtag_xfer(1, 8'h10, 0, 0);
    jtag_xfer(1, 8'hFF, 1, 32'h1);
    jtag_xfer(0, 8'h00, 0, 0);
    jtag_xfer(1, 8'hFF, 0, 0);
    contest(0, 0);
    contest(0, 0);
    contest(1, 1);
    contest(0, 1);
    ea = exp_jaddr;
    jtag_rd = 1; @(negedge clk); jtag_rd = 0; @(negedge clk);
    jtag_rd = 1; @(negedge clk); jtag_rd = 0;
    chk("ovr_err", mon_error, 1);
    wait_ready("ovr_done");
    chk("ovr_dreg", mon_dreg, ref_mem[ea]);
    exp_jaddr = 8'(ea + 1);
    jtag_xfer(0, 8'h00, 0, 0);
    chk("ovr_sticky", mon_error, 1);
    jtag_xfer(1, 8'h05, 0, 0);
    chk("ovr_clear", mon_error, 0);
    ea = exp_jaddr; d = $urandom;
    jtag_rd = 1; jtag_wr = 1; jtag_wdata = d; @(negedge clk); jtag_rd = 0; jtag_wr = 0;
    chk("rdwr_err", mon_error, 1);
    @(negedge clk);
    chk("rdwr_we", ram_we, 1);
    chk("rdwr_addr", ram_addr, ea);
    wait_ready("rdwr_done");
    ref_mem[ea] = d;
    jtag_xfer(1, ea, 0, 0);
    chk("rdwr_clear", mon_error, 0);
    ea = exp_jaddr;
    jtag_rd = 1; @(negedge clk); jtag_rd = 0; @(negedge clk);
    jtag_set_addr = 1; jtag_addr = 8'h77; @(negedge clk); jtag_set_addr = 0;
    wait_ready("fly_done");
    chk("fly_dreg", mon_dreg, ref_mem[ea]);
    exp_jaddr = 8'h77;
    jtag_xfer(0, 8'h00, 0, 0);
    debugack = 0;
    avs_xfer(1, 8'h40, 32'h5A5A5A5A);
    jtag_xfer(1, 8'h40, 0, 0);
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 3);
      debugack = 1'($urandom_range(0, 1));
      case (k)
        0: jtag_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 1, $urandom);
        1: jtag_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 0, 0);
        2: avs_xfer(1, 8'($urandom_range(0, 15)), $urandom);
        default: avs_xfer(0, 8'($urandom_range(0, 15)), 0);
      endcase
    end
    debugack = 0;
    jtag_set_addr = 1; jtag_addr = 8'h50; jtag_wr = 1; jtag_wdata = 32'h12345678;
    @(negedge clk);
    jtag_set_addr = 0; jtag_wr = 0;
    @(negedge clk);
    chk("rst_pre_we", ram_we, 1);
    #1 reset = 1;
    #1 chk("rst_async_we", ram_we, 0);
    @(negedge clk);
    reset = 0;
    exp_jaddr = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    check_reset("rst2");
    jtag_xfer(0, 8'h00, 0, 0);
    jtag_xfer(1, 8'h50, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
